ps2_kbd_dev_io: RTL and testbench

PS2_KBD_DEV_IO -- requirements
Module: ps2_kbd_dev_io

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_fifo.sv | 65 ++++++
 rtl/ps2_kbd_dev_io.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_kbd_dev_io.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard device: receiver FSM encoding,
// clock filter length and kbd_out bit positions.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Consecutive equal samples needed before the filtered ps2_clk changes
  localparam int unsigned FILT_LEN = 8;

  // kbd_out field positions
  localparam int unsigned KO_NE      = 31;
  localparam int unsigned KO_OVF     = 30;
  localparam int unsigned KO_FERR    = 29;
  localparam int unsigned KO_PERR    = 28;
  localparam int unsigned KO_OCC_MSB = 27;
  localparam int unsigned KO_OCC_LSB = 23;
  localparam int unsigned KO_DAT_MSB = 7;

endpackage

// File: rtl/ps2_fifo.sv
// Scancode FIFO: power-of-two depth, simultaneous push/pop, zero head when empty.
module ps2_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] count_o,
  output logic [7:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push to a full FIFO is accepted then
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are masked by empty_o so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ps2_kbd_dev_io.sv
// PS/2 keyboard receiver with scancode FIFO and bus status/data word.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_kbd_dev_io
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        kbd_rd,
  input  logic        kbd_clr,
  output logic [31:0] kbd_out,
  output logic        kbd_int
);

  localparam int unsigned FCW = $clog2(FILT_LEN);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  ps2_state_e     state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           tmo_hit;

  logic           push, ferr_evt, ovf_evt, pop;
  logic           rd_q;
  logic           ovf_q, ovf_d, ferr_q, ferr_d;
  logic           perr_bit;

  logic           f_full, f_empty;
  logic [4:0]     f_count;
  logic [7:0]     f_head;

`ifdef PS2_PARITY_CHECK_EN
  logic           par_q, par_d;
  logic           perr_evt;
  logic           perr_q, perr_d;
`endif

  // Input synchronizers and ps2_clk glitch filter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Filter flips after FILT_LEN consecutive samples disagreeing with it
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = clk_s2_q;
      else                              fcnt_d = fcnt_q + FCW'(1);
    end
  end

  assign fall    = filt_q & ~filt_d;
  assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: one transition per filtered falling edge, timeout aborts
  always_comb begin
    state_d = state_q;
    if (fall) begin
      unique case (state_q)
        ST_IDLE:   if (!dat_s2_q) state_d = ST_DATA;
        ST_DATA:   if (bcnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs: frame verdict on the stop-bit edge
  always_comb begin
    push     = 1'b0;
    ferr_evt = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    perr_evt = 1'b0;
`endif
    if (state_q == ST_STOP && fall) begin
      if (!dat_s2_q) ferr_evt = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
      else if (~^{shift_q, par_q}) perr_evt = 1'b1;
`endif
      else push = 1'b1;
    end
  end

  // Receive datapath next state: shifter, bit counter, idle timer
  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    tmo_d   = (state_q == ST_IDLE || fall) ? '0 : tmo_q + TW'(1);
    if (state_q == ST_IDLE) bcnt_d = '0;
    if (fall && state_q == ST_DATA) begin
      shift_d = {dat_s2_q, shift_q[7:1]};
      bcnt_d  = bcnt_q + 3'd1;
    end
`ifdef PS2_PARITY_CHECK_EN
    par_d = par_q;
    if (fall && state_q == ST_PARITY) par_d = dat_s2_q;
`endif
  end

  // Receive datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  assign pop     = kbd_rd & ~rd_q & ~f_empty;
  assign ovf_evt = push & f_full & ~pop;

  // Sticky flags: a clear loses to an error event in the same cycle
  always_comb begin
    ovf_d  = (ovf_q & ~kbd_clr) | ovf_evt;
    ferr_d = (ferr_q & ~kbd_clr) | ferr_evt;
`ifdef PS2_PARITY_CHECK_EN
    perr_d = (perr_q & ~kbd_clr) | perr_evt;
`endif
  end

  // Flag and read-strobe history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q   <= 1'b0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      perr_q <= 1'b0;
`endif
    end else begin
      rd_q   <= kbd_rd;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
      perr_q <= perr_d;
`endif
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign perr_bit = perr_q;
`else
  assign perr_bit = 1'b0;
`endif

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (shift_q),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count),
    .head_o  (f_head)
  );

  // Bus status/data word
  always_comb begin
    kbd_out                         = '0;
    kbd_out[KO_NE]                  = ~f_empty;
    kbd_out[KO_OVF]                 = ovf_q;
    kbd_out[KO_FERR]                = ferr_q;
    kbd_out[KO_PERR]                = perr_bit;
    kbd_out[KO_OCC_MSB:KO_OCC_LSB]  = f_count;
    kbd_out[KO_DAT_MSB:0]           = f_head;
  end

  assign kbd_int = kbd_out[KO_NE];

endmodule

// File: tb/tb_ps2_kbd_dev_io.sv
// Self-checking bench for ps2_kbd_dev_io; honours PS2_PARITY_CHECK_EN.
module tb_ps2_kbd_dev_io;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 2000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ps2_clk, ps2_data, kbd_rd, kbd_clr;
  logic [31:0] kbd_out;
  logic        kbd_int;

  always #5 clk = ~clk;

  ps2_kbd_dev_io #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd_rd   (kbd_rd),
    .kbd_clr  (kbd_clr),
    .kbd_out  (kbd_out),
    .kbd_int  (kbd_int)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned half  = 15;

  // Reference model: stored bytes and sticky flags
  logic [7:0] mq[$];
  bit         m_ovf, m_ferr, m_perr;

  function automatic logic [31:0] exp_word();
    logic [7:0] hd;
    logic [4:0] occ;
    hd  = 8'h00;
    if (mq.size() != 0) hd = mq[0];
    occ = 5'(mq.size());
    return {(mq.size() != 0), m_ovf, m_ferr, m_perr, occ, 15'b0, hd};
  endfunction

  function automatic logic oddpar(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] e;
    e = exp_word();
    check(tag, kbd_out, e);
    check({tag, "_int"}, {31'b0, kbd_int}, {31'b0, e[31]});
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bit i is driven on ps2_data, then one full ps2_clk low/high period
  task automatic send_bits(input logic [10:0] fr, input int unsigned nb);
    for (int unsigned i = 0; i < nb; i++) begin
      ps2_data = fr[i];
      cyc(half);
      ps2_clk = 1'b0;
      cyc(half);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (!stop)                             m_ferr = 1'b1;
    else if (PAR_EN && ((^{d, par}) == 1'b0)) m_perr = 1'b1;
    else if (mq.size() == DEPTH)           m_ovf  = 1'b1;
    else                                   mq.push_back(d);
  endtask

  task automatic frame(input logic [7:0] d, input logic par, input logic stop, input string tag);
    send_bits(mkframe(d, par, stop), 11);
    model_frame(d, par, stop);
    cyc(2);
    check_state(tag);
  endtask

  task automatic good(input logic [7:0] d, input string tag);
    frame(d, oddpar(d), 1'b1, tag);
  endtask

  task automatic rd(input int unsigned hold, input string tag);
    check_state({tag, "_pre"});
    kbd_rd = 1'b1;
    cyc(hold);
    kbd_rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    cyc(1);
    check_state(tag);
  endtask

  task automatic clr(input string tag);
    kbd_clr = 1'b1;
    cyc(1);
    kbd_clr = 1'b0;
    m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       par, stop;

    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; kbd_rd = 1'b0; kbd_clr = 1'b0;
    cyc(3);
    check("reset_out", kbd_out, exp_word());
    check("reset_int", {31'b0, kbd_int}, 32'd0);
    rst = 1'b1;
    cyc(3);

    // 0x1C frame with exact push latency after the stop-bit edge
    half = 15;
    send_bits(mkframe(8'h1C, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    cyc(half);
    ps2_clk = 1'b0;
    cyc(9);
    check("lat_before", kbd_out, 32'h0000_0000);
    cyc(1);
    check("lat_1c", kbd_out, 32'h8080_001C);
    check("lat_1c_int", {31'b0, kbd_int}, 32'd1);
    mq.push_back(8'h1C);
    cyc(half - 10);
    ps2_clk = 1'b1;
    rd(1, "rd_1c");

    // Nine frames with no reads: overflow, then in-order drain
    for (int unsigned i = 1; i <= 9; i++) good(8'(i), "fill9");
    check("ovf_word", kbd_out, 32'hC400_0001);
    for (int unsigned i = 0; i < 8; i++) rd(1, "drain8");
    clr("clr_ovf");

    // Bad stop bit
    frame(8'h33, oddpar(8'h33), 1'b0, "bad_stop");
    clr("clr_ferr");

    // Parity: 0x55 has four ones, so parity 0 is the failing case
    frame(8'h55, 1'b0, 1'b1, "par55_bad");
    frame(8'h55, 1'b1, 1'b1, "par55_good");
    clr("clr_perr");
    while (mq.size() != 0) rd(2, "par_drain");

    // Long read strobe pops one entry
    good(8'hA1, "hold_a");
    good(8'hB2, "hold_b");
    rd(20, "rd_hold20");
    rd(3, "rd_hold_last");

    // Full FIFO with a pop landing on the push cycle: no overflow, occupancy 8
    for (int unsigned i = 0; i < DEPTH; i++) good(8'(8'h40 + i), "fill_full");
    send_bits(mkframe(8'h77, oddpar(8'h77), 1'b1), 10);
    ps2_data = 1'b1;
    cyc(half);
    ps2_clk = 1'b0;
    cyc(9);
    kbd_rd = 1'b1;
    cyc(1);
    kbd_rd = 1'b0;
    void'(mq.pop_front());
    mq.push_back(8'h77);
    cyc(1);
    check_state("push_pop_same");
    cyc(half - 11);
    ps2_clk = 1'b1;
    while (mq.size() != 0) rd(1, "pp_drain");

    // Partial frame then silence: timeout discards it without flags
    send_bits(mkframe(8'h3C, oddpar(8'h3C), 1'b1), 5);
    cyc(TMO + 100);
    check_state("timeout_idle");
    good(8'h2A, "after_timeout");

    // Reset mid-frame
    send_bits(mkframe(8'h6E, oddpar(8'h6E), 1'b1), 6);
    rst = 1'b0;
    cyc(2);
    mq.delete();
    m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    check("rst_mid_out", kbd_out, 32'h0000_0000);
    check("rst_mid_int", {31'b0, kbd_int}, 32'd0);
    ps2_data = 1'b1;
    rst = 1'b1;
    cyc(3);
    good(8'h5A, "after_reset");

    // Randomized traffic
    for (int unsigned i = 0; i < 14; i++) begin
      half = $urandom_range(12, 25);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = ($urandom_range(0, 4) == 0) ? ~oddpar(d) : oddpar(d);
      frame(d, par, stop, "rand_frame");
      if ($urandom_range(0, 2) == 0) rd($urandom_range(1, 5), "rand_rd");
      if ($urandom_range(0, 5) == 0) clr("rand_clr");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
